// File: rtl/game_pkg.sv
// Shared types, scoring constants and small arithmetic helpers for the
// game flow controller and its frame event latch.
package game_pkg;

  // Encoding is visible on the game_state output and must stay fixed.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_DEATH   = 3'd2,
    ST_RESPAWN = 3'd3,
    ST_CLEAR   = 3'd4,
    ST_OVER    = 3'd5
  } game_state_t;

  // One bit per collision event class, collected over a frame.
  typedef struct packed {
    logic died;
    logic gold;
    logic alien;
    logic emerald;
  } frame_events_t;

  localparam int unsigned PTS_GOLD    = 500;
  localparam int unsigned PTS_ALIEN   = 250;
  localparam int unsigned PTS_EMERALD = 25;
  localparam int unsigned BONUS_STEP  = 20000;

  localparam logic [15:0] SCORE_MAX = 16'hFFFF;
  localparam logic [2:0]  LIVES_MAX = 3'd7;
  localparam logic [3:0]  LEVEL_MAX = 4'd15;

  // Points earned by one committed frame; each class counts at most once.
  function automatic logic [16:0] frame_points(
    input frame_events_t ev,
    input int unsigned   p_gold,
    input int unsigned   p_alien,
    input int unsigned   p_emerald
  );
    logic [16:0] pts;
    pts = '0;
    if (ev.gold)    pts = pts + 17'(p_gold);
    if (ev.alien)   pts = pts + 17'(p_alien);
    if (ev.emerald) pts = pts + 17'(p_emerald);
    return pts;
  endfunction

  // 17-bit sum so a carry out of the 16-bit score pins it at the maximum.
  function automatic logic [15:0] sat_add(
    input logic [15:0] base,
    input logic [16:0] pts
  );
    logic [16:0] sum;
    sum = {1'b0, base} + pts;
    return sum[16] ? SCORE_MAX : sum[15:0];
  endfunction

endpackage

// File: rtl/frame_event_latch.sv
// Sticky per-frame event flags. Events are only collected while enabled
// (the game is in play); the frame-start clock hands the finished frame's
// flags to the commit logic and seeds the next frame with that clock's
// own events so nothing arriving exactly on the boundary is dropped.
module frame_event_latch
  import game_pkg::*;
(
  input  logic          clk,
  input  logic          resetN,
  input  logic          sof,
  input  logic          enable,
  input  frame_events_t events,
  output frame_events_t flags,
  output logic          commit
);

  // Accumulate within a frame, restart on frame start, hold empty while disabled.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      flags <= '0;
    end else if (!enable) begin
      flags <= '0;
    end else if (sof) begin
      flags <= events;
    end else begin
      flags <= frame_events_t'(flags | events);
    end
  end

  // The flags register still holds the finished frame on the frame-start clock.
  assign commit = sof & enable;

endmodule

// File: rtl/game_flow_controller.sv
// Top-level game sequencing: start, play, death freeze, respawn, level
// clear freeze and game over. Scoring and lives are updated once per
// frame from the flags gathered by frame_event_latch.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | after reset, waiting for start_game at a frame start
//   PLAY    | player active, events collected and committed per frame
//   DEATH   | frozen for DEATH_FRAMES frames after the player died
//   RESPAWN | one frame to reload the board before play resumes
//   CLEAR   | frozen for CLEAR_FRAMES frames after the level is emptied
//   OVER    | no lives left, score held until start_game
module game_flow_controller #(
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int unsigned CLEAR_FRAMES = 90,
  parameter int unsigned PTS_GOLD     = game_pkg::PTS_GOLD,
  parameter int unsigned PTS_ALIEN    = game_pkg::PTS_ALIEN,
  parameter int unsigned PTS_EMERALD  = game_pkg::PTS_EMERALD,
  parameter int unsigned BONUS_STEP   = game_pkg::BONUS_STEP
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        start_game,
  input  logic        player_died,
  input  logic        alien_died_a,
  input  logic        player_eat_gold_1,
  input  logic        emerald_eaten,
  input  logic        emeralds_left_zero,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic [3:0]  level,
  output logic [2:0]  game_state,
  output logic        player_awake,
  output logic        level_reset
);

  import game_pkg::*;

  game_state_t   state;
  game_state_t   state_next;
  frame_events_t events;
  frame_events_t flags;
  logic          commit;
  logic          init_game;
  logic          pulse_reset;
  logic          advance_level;
  logic          frame_done;
  logic [7:0]    frame_cnt;
  logic [16:0]   bonus_at;
  logic [15:0]   score_commit;
  logic          bonus;
  logic [2:0]    lives_dec;
  logic [2:0]    lives_commit;

  assign events = '{died:    player_died,
                    gold:    player_eat_gold_1,
                    alien:   alien_died_a,
                    emerald: emerald_eaten};

  frame_event_latch u_frame_event_latch (
    .clk    (clk),
    .resetN (resetN),
    .sof    (startOfFrame),
    .enable (state == ST_PLAY),
    .events (events),
    .flags  (flags),
    .commit (commit)
  );

  // Score, bonus and lives that result from committing the current flags.
  // bonus_at is the next unclaimed BONUS_STEP multiple; a single frame
  // earns far less than one step, so one compare finds any crossing.
  always_comb begin
    score_commit = sat_add(score, frame_points(flags, PTS_GOLD, PTS_ALIEN, PTS_EMERALD));
    bonus        = ({1'b0, score_commit} >= bonus_at);
    lives_dec    = (flags.died && (lives != 3'd0)) ? lives - 3'd1 : lives;
    lives_commit = (bonus && (lives_dec != LIVES_MAX)) ? lives_dec + 3'd1 : lives_dec;
  end

  // Frame-count terminal compare for the two timed freeze states.
  always_comb begin
    frame_done = 1'b0;
    if (startOfFrame) begin
      if (state == ST_DEATH) begin
        frame_done = (frame_cnt == 8'(DEATH_FRAMES - 1));
      end else if (state == ST_CLEAR) begin
        frame_done = (frame_cnt == 8'(CLEAR_FRAMES - 1));
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection plus the one-cycle strobes tied to each transition.
  always_comb begin
    state_next    = state;
    init_game     = 1'b0;
    pulse_reset   = 1'b0;
    advance_level = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (startOfFrame && start_game) begin
          state_next  = ST_PLAY;
          init_game   = 1'b1;
          pulse_reset = 1'b1;
        end
      end
      ST_PLAY: begin
        // Death outranks clear when both land in the same frame.
        if (commit) begin
          if (flags.died) begin
            state_next = ST_DEATH;
          end else if (emeralds_left_zero) begin
            state_next = ST_CLEAR;
          end
        end
      end
      ST_DEATH: begin
        // lives already reflects the decrement applied at the fatal commit.
        if (frame_done) begin
          if (lives != 3'd0) begin
            state_next  = ST_RESPAWN;
            pulse_reset = 1'b1;
          end else begin
            state_next = ST_OVER;
          end
        end
      end
      ST_RESPAWN: begin
        if (startOfFrame) begin
          state_next = ST_PLAY;
        end
      end
      ST_CLEAR: begin
        if (frame_done) begin
          state_next    = ST_PLAY;
          pulse_reset   = 1'b1;
          advance_level = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Frame counter restarts on every state change and advances on frame starts only.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt <= '0;
    end else if (state_next != state) begin
      frame_cnt <= '0;
    end else if (startOfFrame) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Game data: initialised at game start, updated at commits and level clears.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      score    <= '0;
      lives    <= 3'(START_LIVES);
      level    <= 4'd1;
      bonus_at <= 17'(BONUS_STEP);
    end else if (init_game) begin
      score    <= '0;
      lives    <= 3'(START_LIVES);
      level    <= 4'd1;
      bonus_at <= 17'(BONUS_STEP);
    end else begin
      if (commit) begin
        score <= score_commit;
        lives <= lives_commit;
        if (bonus) begin
          bonus_at <= bonus_at + 17'(BONUS_STEP);
        end
      end
      if (advance_level) begin
        level <= (level == LEVEL_MAX) ? 4'd1 : level + 4'd1;
      end
    end
  end

  // Registered status outputs, aligned with the state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      player_awake <= 1'b0;
      level_reset  <= 1'b0;
    end else begin
      player_awake <= (state_next == ST_PLAY);
      level_reset  <= pulse_reset;
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller: directed scenarios for the
// documented corner cases followed by randomized play, all compared every
// clock against a frame-level reference model.
module tb_game_flow_controller;

  localparam int S_IDLE    = 0;
  localparam int S_PLAY    = 1;
  localparam int S_DEATH   = 2;
  localparam int S_RESPAWN = 3;
  localparam int S_CLEAR   = 4;
  localparam int S_OVER    = 5;

  localparam int N_DEATH = 60;
  localparam int N_CLEAR = 90;
  localparam int P_GOLD  = 500;
  localparam int P_ALIEN = 250;
  localparam int P_EMER  = 25;
  localparam int STEP    = 20000;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        start_game = 1'b0;
  logic        player_died = 1'b0;
  logic        alien_died_a = 1'b0;
  logic        player_eat_gold_1 = 1'b0;
  logic        emerald_eaten = 1'b0;
  logic        emeralds_left_zero = 1'b0;
  logic [15:0] score;
  logic [2:0]  lives;
  logic [3:0]  level;
  logic [2:0]  game_state;
  logic        player_awake;
  logic        level_reset;

  int n_checks = 0;
  int n_errors = 0;
  bit done = 1'b0;

  // reference model
  int m_state, m_score, m_lives, m_level, m_frames;
  bit m_lr;
  bit f_died, f_gold, f_alien, f_em;

  game_flow_controller dut (
    .clk                (clk),
    .resetN             (resetN),
    .startOfFrame       (startOfFrame),
    .start_game         (start_game),
    .player_died        (player_died),
    .alien_died_a       (alien_died_a),
    .player_eat_gold_1  (player_eat_gold_1),
    .emerald_eaten      (emerald_eaten),
    .emeralds_left_zero (emeralds_left_zero),
    .score              (score),
    .lives              (lives),
    .level              (level),
    .game_state         (game_state),
    .player_awake       (player_awake),
    .level_reset        (level_reset)
  );

  always #5 clk = ~clk;

  task automatic finish_bench();
    if (!done) begin
      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    if (done) return;
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_score = 0; m_lives = 3; m_level = 1; m_frames = 0; m_lr = 1'b0;
    f_died = 0; f_gold = 0; f_alien = 0; f_em = 0;
  endtask

  // One clock of game rules, applied to the inputs present at the rising edge.
  task automatic model_clock();
    int nxt, pts, old_score, new_score;
    nxt  = m_state;
    m_lr = 1'b0;
    if (m_state == S_PLAY && startOfFrame) begin
      pts = (f_gold ? P_GOLD : 0) + (f_alien ? P_ALIEN : 0) + (f_em ? P_EMER : 0);
      old_score = m_score;
      new_score = old_score + pts;
      if (new_score > 65535) new_score = 65535;
      if (f_died && m_lives > 0) m_lives--;
      if ((new_score / STEP) > (old_score / STEP) && m_lives < 7) m_lives++;
      m_score = new_score;
      if (f_died) nxt = S_DEATH;
      else if (emeralds_left_zero) nxt = S_CLEAR;
    end
    case (m_state)
      S_IDLE, S_OVER: if (startOfFrame && start_game) begin
        nxt = S_PLAY; m_score = 0; m_lives = 3; m_level = 1; m_lr = 1'b1;
      end
      S_DEATH: if (startOfFrame) begin
        m_frames++;
        if (m_frames == N_DEATH) begin
          if (m_lives > 0) begin nxt = S_RESPAWN; m_lr = 1'b1; end
          else nxt = S_OVER;
        end
      end
      S_RESPAWN: if (startOfFrame) nxt = S_PLAY;
      S_CLEAR: if (startOfFrame) begin
        m_frames++;
        if (m_frames == N_CLEAR) begin
          nxt = S_PLAY; m_lr = 1'b1;
          m_level = (m_level == 15) ? 1 : m_level + 1;
        end
      end
      default: ;
    endcase
    if (m_state == S_PLAY) begin
      if (startOfFrame) begin
        f_died = player_died; f_gold = player_eat_gold_1; f_alien = alien_died_a; f_em = emerald_eaten;
      end else begin
        f_died |= player_died; f_gold |= player_eat_gold_1; f_alien |= alien_died_a; f_em |= emerald_eaten;
      end
    end else begin
      f_died = 0; f_gold = 0; f_alien = 0; f_em = 0;
    end
    if (nxt != m_state) m_frames = 0;
    m_state = nxt;
  endtask

  task automatic compare_all();
    check_val("state", int'(game_state), m_state);
    check_val("score", int'(score), m_score);
    check_val("lives", int'(lives), m_lives);
    check_val("level", int'(level), m_level);
    check_val("awake", int'(player_awake), (m_state == S_PLAY) ? 1 : 0);
    check_val("level_reset", int'(level_reset), int'(m_lr));
  endtask

  task automatic cycle(input bit sof, input bit st, input bit d, input bit a,
                       input bit g, input bit e, input bit ez);
    startOfFrame = sof; start_game = st; player_died = d; alien_died_a = a;
    player_eat_gold_1 = g; emerald_eaten = e; emeralds_left_zero = ez;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all();
    if (n_errors > 40) finish_bench();
  endtask

  // One event clock then the frame-start clock that commits it.
  task automatic play_frame(input bit g, input bit a, input bit e, input bit d, input bit ez);
    cycle(1'b0, 1'b0, d, a, g, e, ez);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ez);
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) play_frame(0, 0, 0, 0, 0);
  endtask

  task automatic async_reset_check(input string tag);
    #3 resetN = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_val({tag, "_state"}, int'(game_state), S_IDLE);
    check_val({tag, "_score"}, int'(score), 0);
    check_val({tag, "_lives"}, int'(lives), 3);
    check_val({tag, "_level"}, int'(level), 1);
    check_val({tag, "_awake"}, int'(player_awake), 0);
    check_val({tag, "_lr"}, int'(level_reset), 0);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    check_val("rst_state", int'(game_state), S_IDLE);
    check_val("rst_lives", int'(lives), 3);
    check_val("rst_lr", int'(level_reset), 0);
    resetN = 1'b1;

    // idle frames without start keep IDLE; events ignored
    play_frame(1, 1, 1, 1, 0);
    check_val("idle_ignore_score", int'(score), 0);

    // start game
    cycle(1, 1, 0, 0, 0, 0, 0);
    check_val("start_state", int'(game_state), S_PLAY);
    check_val("start_lives", int'(lives), 3);
    check_val("start_score", int'(score), 0);
    check_val("start_lr", int'(level_reset), 1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check_val("start_lr_one_clk", int'(level_reset), 0);

    // gold held 5 clocks plus one alien hit in one frame
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check_val("gold_alien_score", int'(score), 750);

    // emerald on the frame-start clock belongs to the next frame
    cycle(1, 0, 0, 0, 0, 1, 0);
    check_val("sof_emerald_deferred", int'(score), 750);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check_val("sof_emerald_counted", int'(score), 775);

    // death and clear in the same frame: death wins
    play_frame(0, 0, 0, 1, 1);
    check_val("death_prio_state", int'(game_state), S_DEATH);
    check_val("death_prio_lives", int'(lives), 2);
    idle_frames(N_DEATH - 1);
    check_val("death_hold_state", int'(game_state), S_DEATH);
    idle_frames(1);
    check_val("respawn_state", int'(game_state), S_RESPAWN);
    check_val("respawn_lr", int'(level_reset), 1);
    idle_frames(1);
    check_val("respawn_to_play", int'(game_state), S_PLAY);
    check_val("respawn_score", int'(score), 775);

    // run lives down to zero
    play_frame(0, 0, 0, 1, 0);
    idle_frames(N_DEATH + 1);
    check_val("second_life_play", int'(game_state), S_PLAY);
    check_val("second_life_lives", int'(lives), 1);
    play_frame(0, 0, 0, 1, 0);
    idle_frames(N_DEATH);
    check_val("over_state", int'(game_state), S_OVER);
    check_val("over_lives", int'(lives), 0);
    idle_frames(3);
    check_val("over_hold_score", int'(score), 775);
    cycle(1, 1, 0, 0, 0, 0, 0);
    check_val("restart_state", int'(game_state), S_PLAY);
    check_val("restart_lives", int'(lives), 3);
    check_val("restart_score", int'(score), 0);

    // bonus life on crossing a step, then saturation
    for (int i = 0; i < 39; i++) play_frame(1, 0, 0, 0, 0);
    play_frame(0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) play_frame(0, 0, 1, 0, 0);
    check_val("pre_bonus_score", int'(score), 19975);
    check_val("pre_bonus_lives", int'(lives), 3);
    play_frame(0, 0, 1, 0, 0);
    check_val("bonus_score", int'(score), 20000);
    check_val("bonus_lives", int'(lives), 4);
    for (int i = 0; i < 91; i++) play_frame(1, 0, 0, 0, 0);
    check_val("high_score", int'(score), 65500);
    check_val("high_lives", int'(lives), 6);
    play_frame(1, 0, 0, 0, 0);
    check_val("sat_score", int'(score), 65535);
    play_frame(1, 1, 1, 0, 0);
    check_val("sat_hold_score", int'(score), 65535);

    // randomized play
    for (int f = 0; f < 1500; f++) begin
      int len;
      bit ez;
      len = int'($urandom_range(1, 5));
      ez  = ($urandom_range(0, 99) < 4);
      for (int c = 0; c < len; c++) begin
        cycle((c == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0),
              ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 8),
              ($urandom_range(0, 99) < 10), ez);
      end
    end

    // level clears, including the 15 -> 1 wrap
    async_reset_check("rst_any");
    cycle(1, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      play_frame(0, 0, 0, 0, 1);
      check_val("clear_state", int'(game_state), S_CLEAR);
      idle_frames(N_CLEAR - 1);
      check_val("clear_hold", int'(game_state), S_CLEAR);
      idle_frames(1);
      check_val("clear_to_play", int'(game_state), S_PLAY);
      check_val("clear_level", int'(level), (k % 15) + 1);
      check_val("clear_lr", int'(level_reset), 1);
    end

    // reset in the middle of a clear freeze
    play_frame(0, 0, 0, 0, 1);
    check_val("mid_clear_state", int'(game_state), S_CLEAR);
    idle_frames(30);
    async_reset_check("rst_clear");
    cycle(1, 0, 0, 0, 0, 0, 0);
    check_val("post_rst_state", int'(game_state), S_IDLE);
    check_val("post_rst_lr", int'(level_reset), 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check_val("post_rst_lr2", int'(level_reset), 0);

    finish_bench();
  end

endmodule

// File: doc/game_flow_controller.md
GAME_FLOW_CONTROLLER -- requirements
Module: game_flow_controller

Interface
REQ-001 Parameter START_LIVES, 3, lives loaded at game start and on reset.
REQ-002 Parameter DEATH_FRAMES, 60, frames frozen after the player dies.
REQ-003 Parameter CLEAR_FRAMES, 90, frames frozen after a level is cleared.
REQ-004 Parameter PTS_GOLD / PTS_ALIEN / PTS_EMERALD, 500 / 250 / 25, points per event.
REQ-005 Parameter BONUS_STEP, 20000, a score multiple that awards one extra life.
REQ-006 clk  in  1  system clock.
REQ-007 resetN  in  1  asynchronous active-low reset.
REQ-008 startOfFrame  in  1  one-clock pulse at each frame start.
REQ-009 start_game  in  1  start key, level-sensitive.
REQ-010 player_died / alien_died_a / player_eat_gold_1 / emerald_eaten  in  1 each  pixel-rate collision events.
REQ-011 emeralds_left_zero  in  1  no emeralds remain on the board.
REQ-012 score  out  16  binary score, saturating.
REQ-013 lives  out  3  remaining lives.
REQ-014 level  out  4  current level, 1-based.
REQ-015 game_state  out  3  encoding: IDLE=0, PLAY=1, DEATH=2, RESPAWN=3, CLEAR=4, OVER=5.
REQ-016 player_awake  out  1  high only in PLAY.
REQ-017 level_reset  out  1  one-clock pulse that reloads the board and sprites.

Function
REQ-018 In PLAY, each event input shall set a sticky per-frame flag on any clock it is high; multiple hits in one frame count once.
REQ-019 On a startOfFrame clock, the flags shall be committed and then cleared; an event high on that same clock shall land in the new frame's flags and shall not be lost.
REQ-020 Commit shall add PTS_GOLD, PTS_ALIEN and PTS_EMERALD for each set flag; score and all event outputs shall be registered, visible one clock after the startOfFrame clock.
REQ-021 Score addition shall use a 17-bit sum; a sum above 65535 shall saturate score to 65535.
REQ-022 When a commit crosses a BONUS_STEP multiple, lives shall increment by 1, saturating at 7; at most one bonus per commit.
REQ-023 IDLE -> PLAY on start_game high at startOfFrame: score=0, lives=START_LIVES, level=1, level_reset pulse.
REQ-024 PLAY -> DEATH at commit when the died flag is set; lives shall decrement by 1 at that commit, and score from the same frame is still added.
REQ-025 PLAY -> CLEAR at commit when emeralds_left_zero is high and died is clear; death shall have priority over clear in the same frame.
REQ-026 DEATH shall hold for DEATH_FRAMES startOfFrame pulses, then go to RESPAWN if lives>0, else OVER.
REQ-027 RESPAWN shall last exactly one frame and pulse level_reset on entry, then go to PLAY; level and score are unchanged.
REQ-028 CLEAR shall hold for CLEAR_FRAMES frames, then increment level (wrapping 15->1), pulse level_reset and go to PLAY.
REQ-029 OVER shall hold score; start_game at startOfFrame shall re-enter the IDLE->PLAY init path.
REQ-030 Event inputs outside PLAY shall be ignored and shall not set flags.
REQ-031 The frame counter shall be 8 bits, cleared on every state entry, and count startOfFrame only.

Reset
REQ-032 resetN low shall asynchronously force IDLE, score=0, lives=START_LIVES, level=1, flags=0, counter=0, player_awake=0, level_reset=0.
REQ-033 Reset mid-DEATH or mid-CLEAR shall discard all pending transitions; no level_reset pulse is issued on reset release.

Structure
REQ-034 The state enum, the point constants and BONUS_STEP shall live in the shared package game_pkg.
REQ-035 One sub-module, frame_event_latch, shall implement the sticky flags and commit/clear logic (REQ-018/019).

Verification
REQ-036 start_game at frame start -> game_state=1, lives=3, score=0, one level_reset pulse.
REQ-037 Gold hit 5 clocks plus alien hit in one frame -> score=750 after the next startOfFrame (+1 clk).
REQ-038 player_died with lives=1 -> DEATH for 60 frames, then OVER, lives=0; start_game -> PLAY, lives=3.
REQ-039 Score 19990 plus emerald -> score=20015, lives+1; score 65530 plus gold -> 65535.
REQ-040 emeralds_left_zero and player_died in the same frame -> DEATH, not CLEAR; emerald on the startOfFrame clock is counted in the next commit.
REQ-041 resetN asserted mid-CLEAR -> immediate IDLE and all outputs at reset values.
